// File: rtl/qspi_mem_arbiter.sv
// ---------------------------------------------------------------------------
// qspi_mem_arbiter
//
// Shares one QSPI memory controller between the CPU instruction-fetch port
// and the CPU data port. The controller drives flash, RAM A and RAM B, and
// the chip is picked from the transaction address. Streaming instruction
// fetches are stopped early when a data access is waiting. A limit on
// back-to-back data grants keeps a busy data port from starving fetches.
//
// Optional feature macro: QSPI_ARB_STATS_EN
//   When defined, the block adds three saturating 16-bit statistics
//   counters and their output ports.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   i_req / i_addr     instruction stream request (level) and start address
//   i_word / i_rdata   forwarded instruction words
//   i_end              instruction transaction ended (complete or stopped)
//   d_req / d_write    data request (level) and direction
//   d_addr / d_wdata   data address and write data
//   d_len              bytes minus 1 (0, 1 or 3)
//   d_done / d_rdata   data completion pulse and registered read data
//   m_start .. m_sel   registered command to the QSPI controller
//   m_word / m_rdata   read words returned by the controller
//   m_done             controller finished, chip select released
//   stat_i_grants      instruction grant count (QSPI_ARB_STATS_EN only)
//   stat_d_grants      data grant count (QSPI_ARB_STATS_EN only)
//   stat_preempts      stops caused by a waiting data access (QSPI_ARB_STATS_EN only)
// ---------------------------------------------------------------------------
module qspi_mem_arbiter #(
    parameter int ADDR_W          = 25,
    parameter int DATA_W          = 32,
    parameter int DATA_BURST_MAX  = 4,
    parameter int MIN_INSTR_WORDS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_word,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_end,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_len,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_start,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_write,
    output logic [DATA_W-1:0] m_wdata,
    output logic [1:0]        m_len,
    output logic              m_stream,
    output logic              m_stop,
    output logic [1:0]        m_sel,
    input  logic              m_word,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_done
`ifdef QSPI_ARB_STATS_EN
    ,
    output logic [15:0]       stat_i_grants,
    output logic [15:0]       stat_d_grants,
    output logic [15:0]       stat_preempts
`endif
);

    localparam int RUN_W = $clog2(DATA_BURST_MAX + 1);
    localparam int CNT_W = $clog2(MIN_INSTR_WORDS + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DATA_BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_INSTR_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        I_ACTIVE,
        I_STOP,
        D_ACTIVE
    } state_t;

    state_t             state;
    logic [RUN_W-1:0]   data_run;
    logic [CNT_W-1:0]   word_cnt;

    logic in_instr;
    logic grant_d;
    logic grant_i;
    logic preempt_cond;
    logic stop_now;

    // Address bit 24 selects RAM space; inside it bit 23 picks RAM B over RAM A.
    function automatic logic [1:0] chip_sel(input logic [1:0] space_bits);
        if (!space_bits[1])
            return 2'd0;
        else if (space_bits[0])
            return 2'd2;
        else
            return 2'd1;
    endfunction

    // Arbitration and stop decisions. Data wins in IDLE unless it has already
    // taken DATA_BURST_MAX grants in a row while a fetch is waiting. A running
    // fetch is stopped once it has delivered its minimum words and data waits,
    // or when the fetch port drops its request (branch). m_done takes priority
    // so a finishing transaction is never given a redundant stop.
    always_comb begin
        in_instr     = (state == I_ACTIVE) || (state == I_STOP);
        grant_d      = (state == IDLE) && d_req && (!i_req || (data_run < RUN_MAX));
        grant_i      = (state == IDLE) && !grant_d && i_req;
        preempt_cond = (state == I_ACTIVE) && !m_done && d_req && (word_cnt >= CNT_MAX);
        stop_now     = (state == I_ACTIVE) && !m_done && (preempt_cond || !i_req);
    end

    // Words and completion are passed straight through so the requesters see
    // them in the same cycle as the controller produces them.
    assign i_word  = in_instr && m_word;
    assign i_rdata = in_instr ? m_rdata : '0;
    assign i_end   = in_instr && m_done;
    assign d_done  = (state == D_ACTIVE) && m_done;

    // Main sequencer. The command to the controller is latched at grant and
    // held until m_done; m_start lasts one cycle. The mandatory IDLE cycle
    // between transactions keeps m_start pulses from running back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            data_run <= '0;
            word_cnt <= '0;
            d_rdata  <= '0;
            m_start  <= 1'b0;
            m_addr   <= '0;
            m_write  <= 1'b0;
            m_wdata  <= '0;
            m_len    <= 2'd0;
            m_stream <= 1'b0;
            m_stop   <= 1'b0;
            m_sel    <= 2'd0;
        end else begin
            m_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state    <= D_ACTIVE;
                        m_start  <= 1'b1;
                        m_addr   <= d_addr;
                        m_write  <= d_write;
                        m_wdata  <= d_wdata;
                        m_len    <= d_len;
                        m_stream <= 1'b0;
                        m_sel    <= chip_sel(d_addr[24:23]);
                        if (data_run != RUN_MAX)
                            data_run <= data_run + 1'b1;
                    end else if (grant_i) begin
                        state    <= I_ACTIVE;
                        m_start  <= 1'b1;
                        m_addr   <= i_addr;
                        m_write  <= 1'b0;
                        m_wdata  <= '0;
                        m_len    <= 2'd3;
                        m_stream <= 1'b1;
                        m_sel    <= chip_sel(i_addr[24:23]);
                        data_run <= '0;
                        word_cnt <= '0;
                    end
                end
                I_ACTIVE: begin
                    if (m_done) begin
                        state    <= IDLE;
                        m_stop   <= 1'b0;
                        word_cnt <= '0;
                    end else begin
                        if (m_word && (word_cnt != CNT_MAX))
                            word_cnt <= word_cnt + 1'b1;
                        if (stop_now) begin
                            m_stop <= 1'b1;
                            state  <= I_STOP;
                        end
                    end
                end
                I_STOP: begin
                    if (m_done) begin
                        state    <= IDLE;
                        m_stop   <= 1'b0;
                        word_cnt <= '0;
                    end
                end
                D_ACTIVE: begin
                    if (m_word)
                        d_rdata <= m_rdata;
                    if (m_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef QSPI_ARB_STATS_EN
    // Saturating statistics: grants of each kind, and stops forced by a
    // waiting data access (a branch-only stop is not counted).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_i_grants <= '0;
            stat_d_grants <= '0;
            stat_preempts <= '0;
        end else begin
            if (grant_i && (stat_i_grants != 16'hFFFF))
                stat_i_grants <= stat_i_grants + 16'd1;
            if (grant_d && (stat_d_grants != 16'hFFFF))
                stat_d_grants <= stat_d_grants + 16'd1;
            if (preempt_cond && (stat_preempts != 16'hFFFF))
                stat_preempts <= stat_preempts + 16'd1;
        end
    end
`endif

endmodule
